// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the core-local interruptor and the CSR unit.
//   - register byte offsets within the CLINT window
//   - bus handshake FSM state encoding
//   - byte-strobe merge and masked address match helpers
package clint_pkg;

    localparam logic [15:0] CLINT_OFF_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_OFF_MTIME_HI    = 16'hBFFC;

    typedef enum logic {
        CLINT_IDLE = 1'b0,
        CLINT_RESP = 1'b1
    } clint_state_e;

    // Replace the bytes of old_val selected by be with the matching bytes of new_val.
    function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address match restricted to the bits the block actually decodes.
    function automatic logic clint_hit(input logic [15:0] addr,
                                       input logic [15:0] off,
                                       input logic [15:0] mask);
        return ((addr & mask) == (off & mask));
    endfunction

endpackage

// File: rtl/clint_if.sv
// clint_if: simple valid/ready register bus between a requester and the CLINT.
//   valid  : request pending, held by the master until ready
//   ready  : one-cycle completion pulse from the slave
//   addr   : word-aligned byte address
//   wmask  : byte write strobes, all zero means read
//   wdata  : write data
//   rdata  : read data, meaningful only while ready=1 (0 otherwise)
interface clint_if;
    logic        valid;
    logic        ready;
    logic [15:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, addr, wmask, wdata, input  ready, rdata);
    modport slave  (input  valid, addr, wmask, wdata, output ready, rdata);
endinterface

// File: rtl/clint_mtime.sv
// clint_mtime: prescaler plus 64-bit machine timer.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   i_tick_en  : enables the prescaler (and therefore mtime ticks)
//   i_wr_lo    : byte strobes for a write to the low mtime word
//   i_wr_hi    : byte strobes for a write to the high mtime word
//   i_wdata    : write data for either word
//   o_mtime    : current 64-bit count
// The prescaler counts 0..TICK_DIV-1 and ticks mtime on its last value.
// A write in a tick cycle wins and the tick is dropped; the prescaler keeps
// running so the tick phase is unaffected by bus traffic.
module clint_mtime
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_tick_en,
    input  logic [3:0]  i_wr_lo,
    input  logic [3:0]  i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_mtime
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_presc;
    logic [63:0] r_mtime;
    logic        w_tick;
    logic        w_wr;

    assign w_tick = i_tick_en && (r_presc == PRESC_LAST);
    assign w_wr   = (i_wr_lo != 4'b0000) || (i_wr_hi != 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= 16'd0;
            r_mtime <= 64'd0;
        end else begin
            if (i_tick_en) begin
                r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            end
            if (w_wr) begin
                r_mtime <= {clint_merge(r_mtime[63:32], i_wdata, i_wr_hi),
                            clint_merge(r_mtime[31:0],  i_wdata, i_wr_lo)};
            end else if (w_tick) begin
                // full 64-bit add: low-to-high carry and the all-ones wrap happen in one cycle
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

    assign o_mtime = r_mtime;

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor (msip, mtime, mtimecmp) on a valid/ready bus.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : clint_if.slave register port (valid/ready/addr/wmask/wdata/rdata)
//   IRQ3       : machine software interrupt, straight from msip bit 0
//   IRQ7       : machine timer interrupt, registered (mtime >= mtimecmp)
// Parameters: TICK_DIV clk cycles per mtime tick, BASE_MASK decoded address bits.
// Build option: define CLINT_MTIME_WRITE_EN to make mtime writable from the bus;
// otherwise mtime writes are dropped but still complete with ready.
//
// Bus FSM
//   state      | meaning
//   CLINT_IDLE | waiting for valid; a request is sampled, written and read here
//   CLINT_RESP | ready=1 with captured rdata; new requests are not taken
module clint
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [15:0] BASE_MASK = 16'hFFFF
)(
    input  logic   clk,
    input  logic   reset,
    clint_if.slave bus,
    output logic   IRQ3,
    output logic   IRQ7
);

    clint_state_e r_state;
    logic         r_ready;
    logic [31:0]  r_rdata;
    logic         r_msip;
    logic [63:0]  r_mtimecmp;
    logic         r_irq7;

    logic         w_accept;
    logic         w_write;
    logic         w_hit_msip;
    logic         w_hit_cmp_lo;
    logic         w_hit_cmp_hi;
    logic         w_hit_mt_lo;
    logic         w_hit_mt_hi;
    logic [31:0]  w_rd_val;
    logic [63:0]  w_mtime;
    logic [3:0]   w_mt_wr_lo;
    logic [3:0]   w_mt_wr_hi;

    assign w_accept     = (r_state == CLINT_IDLE) && bus.valid;
    assign w_write      = (bus.wmask != 4'b0000);
    assign w_hit_msip   = clint_hit(bus.addr, CLINT_OFF_MSIP,        BASE_MASK);
    assign w_hit_cmp_lo = clint_hit(bus.addr, CLINT_OFF_MTIMECMP_LO, BASE_MASK);
    assign w_hit_cmp_hi = clint_hit(bus.addr, CLINT_OFF_MTIMECMP_HI, BASE_MASK);
    assign w_hit_mt_lo  = clint_hit(bus.addr, CLINT_OFF_MTIME_LO,    BASE_MASK);
    assign w_hit_mt_hi  = clint_hit(bus.addr, CLINT_OFF_MTIME_HI,    BASE_MASK);

    // mtime is read as the pre-tick value since the capture uses the current register.
    always_comb begin
        w_rd_val = 32'h0;
        if (w_hit_msip) begin
            w_rd_val = {31'b0, r_msip};
        end else if (w_hit_cmp_lo) begin
            w_rd_val = r_mtimecmp[31:0];
        end else if (w_hit_cmp_hi) begin
            w_rd_val = r_mtimecmp[63:32];
        end else if (w_hit_mt_lo) begin
            w_rd_val = w_mtime[31:0];
        end else if (w_hit_mt_hi) begin
            w_rd_val = w_mtime[63:32];
        end
    end

`ifdef CLINT_MTIME_WRITE_EN
    assign w_mt_wr_lo = (w_accept && w_hit_mt_lo) ? bus.wmask : 4'b0000;
    assign w_mt_wr_hi = (w_accept && w_hit_mt_hi) ? bus.wmask : 4'b0000;
`else
    assign w_mt_wr_lo = 4'b0000;
    assign w_mt_wr_hi = 4'b0000;
`endif

    clint_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk       (clk),
        .reset     (reset),
        .i_tick_en (1'b1),
        .i_wr_lo   (w_mt_wr_lo),
        .i_wr_hi   (w_mt_wr_hi),
        .i_wdata   (bus.wdata),
        .o_mtime   (w_mtime)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLINT_IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                CLINT_IDLE: begin
                    if (bus.valid) begin
                        r_state <= CLINT_RESP;
                        r_ready <= 1'b1;
                        r_rdata <= w_rd_val;
                    end
                end
                CLINT_RESP: begin
                    r_state <= CLINT_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= 32'h0;
                end
                default: begin
                    r_state <= CLINT_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_accept && w_write) begin
            if (w_hit_msip && bus.wmask[0]) begin
                r_msip <= bus.wdata[0];
            end
            if (w_hit_cmp_lo) begin
                r_mtimecmp[31:0] <= clint_merge(r_mtimecmp[31:0], bus.wdata, bus.wmask);
            end
            if (w_hit_cmp_hi) begin
                r_mtimecmp[63:32] <= clint_merge(r_mtimecmp[63:32], bus.wdata, bus.wmask);
            end
        end
    end

    // One cycle of lag is intentional: a fresh mtimecmp write is reflected on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq7 <= 1'b0;
        end else begin
            r_irq7 <= (w_mtime >= r_mtimecmp);
        end
    end

    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;
    assign IRQ3      = r_msip;
    assign IRQ7      = r_irq7;

endmodule

// File: tb/tb_clint.sv
module tb_clint;

    localparam int TB_DIV = 4;

    logic clk;
    logic rst;
    logic irq3;
    logic irq7;

    clint_if bus_if ();

    clint #(
        .TICK_DIV  (TB_DIV),
        .BASE_MASK (16'hFFFF)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if),
        .IRQ3  (irq3),
        .IRQ7  (irq7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timer ticks on every TB_DIV-th clock edge counted from reset; a bus access
    // is taken whenever valid is seen while no response is outstanding.
    logic        m_resp;
    logic [31:0] m_rdata;
    logic        m_msip;
    logic [63:0] m_cmp;
    logic [63:0] m_mtime;
    logic        m_irq7;
    int          m_cyc;
    logic        m_acc;

    assign m_acc = bus_if.valid && !m_resp;

    function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] m);
        logic [31:0] bm;
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (o & ~bm) | (n & bm);
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        case (a)
            16'h0000: return {31'b0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] ref_next_mtime();
        logic [63:0] t;
        t = ((m_cyc % TB_DIV) == TB_DIV - 1) ? m_mtime + 64'd1 : m_mtime;
`ifdef CLINT_MTIME_WRITE_EN
        if (m_acc && bus_if.wmask != 4'h0) begin
            if (bus_if.addr == 16'hBFF8)
                t = {m_mtime[63:32], ref_merge(m_mtime[31:0], bus_if.wdata, bus_if.wmask)};
            else if (bus_if.addr == 16'hBFFC)
                t = {ref_merge(m_mtime[63:32], bus_if.wdata, bus_if.wmask), m_mtime[31:0]};
        end
`endif
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_resp  <= 1'b0;
            m_rdata <= 32'h0;
            m_msip  <= 1'b0;
            m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_mtime <= 64'h0;
            m_irq7  <= 1'b0;
            m_cyc   <= 0;
        end else begin
            m_irq7  <= (m_mtime >= m_cmp);
            m_resp  <= m_acc;
            m_rdata <= m_acc ? ref_read(bus_if.addr) : 32'h0;
            m_mtime <= ref_next_mtime();
            m_cyc   <= m_cyc + 1;
            if (m_acc && bus_if.wmask != 4'h0) begin
                if (bus_if.addr == 16'h0000 && bus_if.wmask[0]) m_msip <= bus_if.wdata[0];
                if (bus_if.addr == 16'h4000)
                    m_cmp[31:0] <= ref_merge(m_cmp[31:0], bus_if.wdata, bus_if.wmask);
                if (bus_if.addr == 16'h4004)
                    m_cmp[63:32] <= ref_merge(m_cmp[63:32], bus_if.wdata, bus_if.wmask);
            end
        end
    end

    // Every cycle, all outputs against the model.
    always @(negedge clk) begin
        check_eq("ready", 64'(bus_if.ready), 64'(m_resp));
        check_eq("rdata", 64'(bus_if.rdata), 64'(m_rdata));
        check_eq("irq3",  64'(irq3),         64'(m_msip));
        check_eq("irq7",  64'(irq7),         64'(m_irq7));
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge where ready was seen.
    task automatic bus_xfer(input logic [15:0] a, input logic [3:0] m, input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        bus_if.valid = 1'b1;
        bus_if.addr  = a;
        bus_if.wmask = m;
        bus_if.wdata = d;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus_if.ready) begin
                lat = i;
                rd  = bus_if.rdata;
                break;
            end
        end
        bus_if.valid = 1'b0;
        bus_if.wmask = 4'h0;
        check_eq("bus_ready_seen", 64'(lat != 0), 64'd1);
    endtask

    task automatic do_reset();
        bus_if.valid = 1'b0;
        bus_if.wmask = 4'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_addr(input int idx);
        case (idx)
            0: return 16'h0000;
            1: return 16'h4000;
            2: return 16'h4004;
            3: return 16'hBFF8;
            4: return 16'hBFFC;
            5: return 16'h0004;
            6: return 16'h8000;
            default: return 16'hBFF4;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] snap;
        logic [63:0] t;
        int          lat, j, k, cnt, idx;

        rst          = 1'b1;
        bus_if.valid = 1'b0;
        bus_if.addr  = 16'h0;
        bus_if.wmask = 4'h0;
        bus_if.wdata = 32'h0;

        // reset values while held in reset
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(bus_if.ready), 64'd0);
        check_eq("rst_rdata", 64'(bus_if.rdata), 64'd0);
        check_eq("rst_irq3",  64'(irq3), 64'd0);
        check_eq("rst_irq7",  64'(irq7), 64'd0);
        rst = 1'b0;

        // first read after reset: mtimecmp high, one-cycle latency
        bus_xfer(16'h4004, 4'h0, 32'h0, rd, lat);
        check_eq("cmp_hi_reset", 64'(rd), 64'hFFFF_FFFF);
        check_eq("first_latency", 64'(lat), 64'd1);
        check_eq("irq3_after_rst", 64'(irq3), 64'd0);
        check_eq("irq7_after_rst", 64'(irq7), 64'd0);

        // msip set / clear / upper bits read zero
        @(negedge clk);
        bus_xfer(16'h0000, 4'h1, 32'h1, rd, lat);
        @(negedge clk);
        check_eq("irq3_set", 64'(irq3), 64'd1);
        bus_xfer(16'h0000, 4'hF, 32'h0, rd, lat);
        @(negedge clk);
        check_eq("irq3_clr", 64'(irq3), 64'd0);
        bus_xfer(16'h0000, 4'hF, 32'hFFFF_FFFF, rd, lat);
        @(negedge clk);
        bus_xfer(16'h0000, 4'h0, 32'h0, rd, lat);
        check_eq("msip_upper_zero", 64'(rd), 64'd1);
        @(negedge clk);
        bus_xfer(16'h0000, 4'h1, 32'h0, rd, lat);

        // unmapped offset: write ignored, reads zero
        @(negedge clk);
        bus_xfer(16'h0008, 4'hF, 32'hDEAD_BEEF, rd, lat);
        @(negedge clk);
        bus_xfer(16'h0008, 4'h0, 32'h0, rd, lat);
        check_eq("unmapped_read", 64'(rd), 64'd0);

        // valid held high: one completion every two cycles
        @(negedge clk);
        bus_if.valid = 1'b1;
        bus_if.addr  = 16'h4000;
        bus_if.wmask = 4'h0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.ready) cnt++;
        end
        bus_if.valid = 1'b0;
        check_eq("b2b_ready_count", 64'(cnt), 64'd3);
        @(negedge clk);

        // timer interrupt: mtimecmp = 10
        do_reset();
        bus_xfer(16'h4004, 4'hF, 32'h0, rd, lat);
        @(negedge clk);
        bus_xfer(16'h4000, 4'hF, 32'd10, rd, lat);
        cnt = m_cyc;
        t   = m_mtime;
        j   = 0;
        while (t < 64'd10 && j < 1000) begin
            j++;
            if ((cnt % TB_DIV) == TB_DIV - 1) t = t + 64'd1;
            cnt++;
        end
        k = 0;
        while (!irq7 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("irq7_rise_latency", 64'(k), 64'(j + 1));
        bus_xfer(16'h4000, 4'hF, 32'd100, rd, lat);
        check_eq("irq7_lags_write", 64'(irq7), 64'd1);
        @(negedge clk);
        check_eq("irq7_cleared", 64'(irq7), 64'd0);

        // mtime write landing exactly on a tick edge
        do_reset();
        k = 0;
        while ((m_cyc % TB_DIV) != TB_DIV - 1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        snap = m_mtime[31:0];
        bus_xfer(16'hBFF8, 4'hF, 32'h1234_5678, rd, lat);
        @(negedge clk);
        bus_xfer(16'hBFF8, 4'h0, 32'h0, rd, lat);
`ifdef CLINT_MTIME_WRITE_EN
        check_eq("mtime_wr_on_tick", 64'(rd), 64'h1234_5678);
`else
        check_eq("mtime_ro_on_tick", 64'(rd), 64'(snap + 32'd1));
`endif

`ifdef CLINT_MTIME_WRITE_EN
        // carry from low word into high word
        @(negedge clk);
        bus_xfer(16'hBFFC, 4'hF, 32'h0, rd, lat);
        @(negedge clk);
        bus_xfer(16'hBFF8, 4'hF, 32'hFFFF_FFFF, rd, lat);
        k = 0;
        while (m_mtime[63:32] != 32'h1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        bus_xfer(16'hBFFC, 4'h0, 32'h0, rd, lat);
        check_eq("carry_hi", 64'(rd), 64'd1);
        @(negedge clk);
        bus_xfer(16'hBFF8, 4'h0, 32'h0, rd, lat);
        check_eq("carry_lo", 64'(rd), 64'd0);
`endif

        // reset while in RESP after a write was taken
        @(negedge clk);
        bus_if.valid = 1'b1;
        bus_if.addr  = 16'h0000;
        bus_if.wmask = 4'h1;
        bus_if.wdata = 32'h1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_ready", 64'(bus_if.ready), 64'd0);
        check_eq("abort_irq3",  64'(irq3), 64'd0);
        check_eq("abort_rdata", 64'(bus_if.rdata), 64'd0);
        bus_if.valid = 1'b0;
        bus_if.wmask = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_xfer(16'h0000, 4'h0, 32'h0, rd, lat);
        check_eq("abort_msip", 64'(rd), 64'd0);

        // reset asserted with a write pending, held for a few cycles
        @(negedge clk);
        bus_if.valid = 1'b1;
        bus_if.addr  = 16'h4004;
        bus_if.wmask = 4'hF;
        bus_if.wdata = 32'h0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("pend_no_ready", 64'(bus_if.ready), 64'd0);
        end
        bus_if.valid = 1'b0;
        bus_if.wmask = 4'h0;
        rst = 1'b0;
        @(negedge clk);
        bus_xfer(16'h4004, 4'h0, 32'h0, rd, lat);
        check_eq("pend_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
        check_eq("pend_irq7", 64'(irq7), 64'd0);

        // randomized traffic, checked cycle by cycle against the model
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            if (!bus_if.valid || bus_if.ready) begin
                if ($urandom_range(0, 3) != 0) begin
                    idx = int'($urandom_range(0, 7));
                    bus_if.valid = 1'b1;
                    bus_if.addr  = pick_addr(idx);
                    bus_if.wmask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    case (idx)
                        1: bus_if.wdata = m_mtime[31:0] + $urandom_range(0, 30);
                        2: bus_if.wdata = ($urandom_range(0, 1) == 0) ? m_mtime[63:32] : $urandom;
                        3: bus_if.wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 : $urandom;
                        4: bus_if.wdata = ($urandom_range(0, 1) == 0) ? m_mtime[63:32] : $urandom;
                        default: bus_if.wdata = $urandom;
                    endcase
                end else begin
                    bus_if.valid = 1'b0;
                    bus_if.wmask = 4'h0;
                end
            end
            @(negedge clk);
        end
        bus_if.valid = 1'b0;
        bus_if.wmask = 4'h0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
